display_ctrl: RTL and testbench
===============================

# display_ctrl

Display sequencer feeding the seven-segment message memory. It turns game events (start, win, lose) into the `displayAddr`/`modo` pair consumed by `displayMem`. It holds the level banner during play and blinks the win/lose message a fixed number of times. It then blanks the display and signals completion to the game controller.

## Interface

Parameters:
- `BLINK_CYCLES`, default 25000000: length of one ON or OFF blink phase, in clock cycles, ≥1.
- `N_BLINKS`, default 3: number of ON/OFF pairs shown per result message, ≥1.

Ports:
- `clock` input 1: system clock, rising-edge.
- `reset` input 1: synchronous, active-high.
- `iniciar` input 1: start/restart pulse; level is sampled with it.
- `nivel` input 2: current game level 0..3.
- `venceu` input 1: win event pulse.
- `perdeu` input 1: lose event pulse.
- `displayAddr` output 2: message select. 00 = level banner, 01 = win message, 10 = lose message, 11 = blank.
- `modo` output 2: latched level shown by the banner.
- `ocupado` output 1: high while a result message sequence runs.
- `fim_msg` output 1: one-cycle pulse when a result sequence completes.

## Operation

- States: APAGADO, NIVEL, RES_ON, RES_OFF.
- `displayAddr` per state:
  - APAGADO: 11.
  - NIVEL: 00.
  - RES_ON: 01 if the latched result is win, 10 if it is lose.
  - RES_OFF: 11.
- Result flag: 1-bit, latched on entry to RES_ON; 0 = win, 1 = lose.
- `modo` is a register:
  - Loaded from `nivel` only when `iniciar` is accepted.
  - Holds otherwise, in every state.
  - Changes on `nivel` without `iniciar` have no effect.
- Transitions:
  - APAGADO, `iniciar` → NIVEL, load `modo`.
  - APAGADO, `venceu`/`perdeu`: ignored.
  - NIVEL, `iniciar` → stay in NIVEL, reload `modo`.
  - NIVEL, `perdeu` → RES_ON with result = lose.
  - NIVEL, `venceu` (no `perdeu`) → RES_ON with result = win.
  - RES_ON, phase counter reaches `BLINK_CYCLES`-1 → RES_OFF.
  - RES_OFF, phase counter reaches terminal, blink count < `N_BLINKS`-1 → RES_ON, increment blink count.
  - RES_OFF, phase counter reaches terminal, blink count = `N_BLINKS`-1 → APAGADO, pulse `fim_msg`.
  - RES_ON/RES_OFF, `iniciar` → abort to NIVEL, load `modo`. No `fim_msg` pulse.
  - RES_ON/RES_OFF, `venceu`/`perdeu`: ignored.
- Priority of simultaneous inputs in the same cycle: `iniciar` > `perdeu` > `venceu`.
- Counters:
  - Phase counter: width ceil(log2(`BLINK_CYCLES`)), minimum 1 bit. Cleared on every state change; counts 0..`BLINK_CYCLES`-1.
  - Blink counter: width ceil(log2(`N_BLINKS`)), minimum 1 bit. Cleared on entry to RES_ON from NIVEL.
  - Neither counter wraps past its terminal value; the state change clears it first.
- `ocupado` = 1 exactly in RES_ON and RES_OFF.
- Total result sequence: 2·`N_BLINKS`·`BLINK_CYCLES` cycles from the first RES_ON cycle to the first APAGADO cycle.

## Timing

- All outputs are registered; no combinational input-to-output path.
- Reset values (applied at the first rising edge with `reset`=1; `reset` overrides all inputs):
  - state APAGADO, `displayAddr`=11, `modo`=00.
  - `ocupado`=0, `fim_msg`=0, both counters 0.
- Reset mid-sequence returns to APAGADO with no `fim_msg` pulse.
- Event latency: an input sampled at edge k changes `displayAddr`/`modo` immediately after edge k, i.e. in cycle k+1. `displayMem` adds one more register stage, so HEX changes after edge k+1.
- Phase length: each RES_ON and RES_OFF phase lasts exactly `BLINK_CYCLES` cycles.
- `fim_msg`: high for exactly the first cycle in APAGADO after a completed sequence; low in all other cycles.
- Input pulses are single-cycle and synchronous to `clock`. A level held high is treated as a pulse in every cycle it is high:
  - `iniciar` held in NIVEL re-latches `modo` each cycle.
  - A held `venceu` in RES states is ignored.

## Test plan

Parameters for all benches: `BLINK_CYCLES`=4, `N_BLINKS`=2.

1. Reset → `displayAddr`=11, `modo`=00, `ocupado`=0, `fim_msg`=0. Events before `iniciar` leave `displayAddr` at 11.
2. `nivel`=2, `iniciar` pulse → next cycle `displayAddr`=00, `modo`=10. Change `nivel` to 1 without `iniciar` → `modo` stays 10.
3. From NIVEL, pulse `venceu` → `displayAddr` sequence 01×4, 11×4, 01×4, 11×4, then 11 with `fim_msg`=1 for one cycle. `ocupado`=1 for exactly those 16 cycles.
4. From NIVEL, assert `venceu` and `perdeu` in the same cycle → RES_ON shows 10 (lose), not 01.
5. During the second RES_ON, pulse `iniciar` with `nivel`=3 → next cycle `displayAddr`=00, `modo`=11, `ocupado`=0. No `fim_msg` pulse is ever asserted.
6. Assert `reset` in RES_OFF → next cycle all outputs at reset values, no `fim_msg`. A later `iniciar` restarts normally.

Source files
------------

// File: rtl/display_ctrl.sv
// Display sequencer: maps game events onto the displayMem message select and
// blinks the win/lose message N_BLINKS times before blanking.
module display_ctrl #(
  parameter int BLINK_CYCLES = 25000000,
  parameter int N_BLINKS     = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] nivel,
  input  logic       venceu,
  input  logic       perdeu,
  output logic [1:0] displayAddr,
  output logic [1:0] modo,
  output logic       ocupado,
  output logic       fim_msg
);

  localparam int PW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int BW = (N_BLINKS > 1) ? $clog2(N_BLINKS) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(BLINK_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(N_BLINKS - 1);

  typedef enum logic [1:0] {
    APAGADO,
    NIVEL,
    RES_ON,
    RES_OFF
  } state_t;

  state_t        state, state_nx;
  logic          lose, lose_nx;
  logic [PW-1:0] phase, phase_nx;
  logic [BW-1:0] blink, blink_nx;
  logic          load_modo;
  logic          fim_nx;
  logic [1:0]    addr_nx;

  always_comb begin
    state_nx  = state;
    lose_nx   = lose;
    blink_nx  = blink;
    load_modo = 1'b0;
    fim_nx    = 1'b0;
    case (state)
      APAGADO: begin
        if (iniciar) begin
          state_nx  = NIVEL;
          load_modo = 1'b1;
        end
      end
      NIVEL: begin
        if (iniciar) begin
          load_modo = 1'b1;
        end else if (perdeu || venceu) begin
          state_nx = RES_ON;
          lose_nx  = perdeu;
          blink_nx = '0;
        end
      end
      RES_ON: begin
        if (iniciar) begin
          state_nx  = NIVEL;
          load_modo = 1'b1;
        end else if (phase == PHASE_LAST) begin
          state_nx = RES_OFF;
        end
      end
      RES_OFF: begin
        if (iniciar) begin
          state_nx  = NIVEL;
          load_modo = 1'b1;
        end else if (phase == PHASE_LAST) begin
          if (blink == BLINK_LAST) begin
            state_nx = APAGADO;
            fim_nx   = 1'b1;
          end else begin
            state_nx = RES_ON;
            blink_nx = blink + BW'(1);
          end
        end
      end
      default: state_nx = APAGADO;
    endcase
  end

  // Phase only runs inside the result states; any state change restarts it.
  always_comb begin
    phase_nx = '0;
    if (state_nx == state && (state == RES_ON || state == RES_OFF))
      phase_nx = phase + PW'(1);
  end

  // Outputs are decoded from the next state so they appear as registers.
  always_comb begin
    addr_nx = 2'b11;
    case (state_nx)
      NIVEL:   addr_nx = 2'b00;
      RES_ON:  addr_nx = lose_nx ? 2'b10 : 2'b01;
      default: addr_nx = 2'b11;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= APAGADO;
      lose        <= 1'b0;
      phase       <= '0;
      blink       <= '0;
      displayAddr <= 2'b11;
      modo        <= 2'b00;
      ocupado     <= 1'b0;
      fim_msg     <= 1'b0;
    end else begin
      state       <= state_nx;
      lose        <= lose_nx;
      phase       <= phase_nx;
      blink       <= blink_nx;
      displayAddr <= addr_nx;
      ocupado     <= (state_nx == RES_ON) || (state_nx == RES_OFF);
      fim_msg     <= fim_nx;
      if (load_modo)
        modo <= nivel;
    end
  end

endmodule

// File: tb/tb_display_ctrl.sv
// Scoreboard bench for display_ctrl: a timeline model predicts every cycle's
// outputs; a monitor pops and compares them one cycle after each drive.
module tb_display_ctrl;

  localparam int BC = 4;
  localparam int NB = 2;

  logic       clock = 1'b0;
  logic       reset, iniciar, venceu, perdeu;
  logic [1:0] nivel;
  logic [1:0] displayAddr, modo;
  logic       ocupado, fim_msg;

  display_ctrl #(.BLINK_CYCLES(BC), .N_BLINKS(NB)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .nivel(nivel),
    .venceu(venceu), .perdeu(perdeu), .displayAddr(displayAddr),
    .modo(modo), .ocupado(ocupado), .fim_msg(fim_msg)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] addr;
    logic [1:0] modo;
    logic       ocup;
    logic       fim;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model: mode 0 = blank, 1 = level banner, 2 = result sequence at time t.
  int       m_mode = 0;
  int       m_t    = 0;
  logic [1:0] m_lvl = 2'b00;
  logic     m_lose = 1'b0;
  logic     m_fim  = 1'b0;

  task automatic cyc(input logic rst, input logic ini, input logic [1:0] niv,
                     input logic ven, input logic per);
    exp_t e;
    @(negedge clock);
    reset = rst; iniciar = ini; nivel = niv; venceu = ven; perdeu = per;
    m_fim = 1'b0;
    if (rst) begin
      m_mode = 0; m_lvl = 2'b00;
    end else if (ini) begin
      m_mode = 1; m_lvl = niv;
    end else if (m_mode == 1 && (per || ven)) begin
      m_mode = 2; m_lose = per; m_t = 0;
    end else if (m_mode == 2) begin
      m_t++;
      if (m_t == 2 * NB * BC) begin
        m_mode = 0; m_fim = 1'b1;
      end
    end
    e.modo = m_lvl;
    e.fim  = m_fim;
    e.ocup = (m_mode == 2);
    if (m_mode == 1) e.addr = 2'b00;
    else if (m_mode == 2 && ((m_t / BC) % 2 == 0)) e.addr = m_lose ? 2'b10 : 2'b01;
    else e.addr = 2'b11;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [1:0] niv);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, niv, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks += 4;
        if (displayAddr !== e.addr) begin
          errors++;
          $display("FAIL displayAddr t=%0t got=%b exp=%b", $time, displayAddr, e.addr);
        end
        if (modo !== e.modo) begin
          errors++;
          $display("FAIL modo t=%0t got=%b exp=%b", $time, modo, e.modo);
        end
        if (ocupado !== e.ocup) begin
          errors++;
          $display("FAIL ocupado t=%0t got=%b exp=%b", $time, ocupado, e.ocup);
        end
        if (fim_msg !== e.fim) begin
          errors++;
          $display("FAIL fim_msg t=%0t got=%b exp=%b", $time, fim_msg, e.fim);
        end
      end
    end
  end

  initial begin : driver
    int budget;
    reset = 1'b1; iniciar = 1'b0; nivel = 2'b00; venceu = 1'b0; perdeu = 1'b0;
    // reset, then events before any start
    cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    // start at level 2, then level change without iniciar
    cyc(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    idle(2, 2'b01);
    // full win sequence
    cyc(1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    idle(19, 2'b01);
    // simultaneous win+lose, abort during second RES_ON
    cyc(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'b01, 1'b1, 1'b1);
    idle(9, 2'b01);
    cyc(1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
    idle(2, 2'b00);
    // iniciar held in NIVEL relatches each cycle
    cyc(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    // reset in RES_OFF, then restart
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    idle(5, 2'b00);
    cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    idle(2, 2'b00);
    cyc(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    idle(2, 2'b00);
    // randomized traffic; held venceu in RES states is exercised here too
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 39) == 0),
          2'($urandom_range(0, 3)),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 7) == 0));
    end
    idle(2, 2'b00);
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clock);
      budget--;
    end
    @(posedge clock);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
